slice_dispatcher: RTL and testbench
===================================

SLICE_DISPATCHER -- requirements
Module: slice_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_PARSER, default 6, number of 2nd-level parsers (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 144, slice data width.
REQ-003 The block SHALL have parameter POS_W / ADDR_W, default 16 / 17, position and address widths.
REQ-004 The block SHALL have parameter START_IDX, default 0, first parser index searched after reset.
REQ-005 The block SHALL have parameter ARB_MODE, default 0, where 0 = round-robin and 1 = fixed priority (lowest index wins).
REQ-006 The block SHALL have ports clk in 1 (clock) and rst_n in 1 (reset); one clock; reset is synchronous and active-low.
REQ-007 The block SHALL have inputs data_in DATA_W, position_in POS_W, address_in ADDR_W, garbage_in 3 and lit_flag_in 1, forming the slice from the show-ahead slice FIFO.
REQ-008 The block SHALL have input valid_in 1, asserted when the FIFO is non-empty.
REQ-009 The block SHALL have output rdreq 1, the FIFO pop, valid the same cycle the slice is captured.
REQ-010 The block SHALL have input stop 1, which halts fetching.
REQ-011 The block SHALL have input ready NUM_PARSER, per-parser idle flag.
REQ-012 The block SHALL have outputs data_out, position_out, address_out, garbage_out and lit_flag_out (widths as inputs), carrying the registered slice.
REQ-013 The block SHALL have output valid_out NUM_PARSER, a one-hot dispatch pulse.
REQ-014 The block SHALL have output idle 1, high when the buffer is empty and stop_reg is high.
REQ-015 The block SHALL have output dispatch_cnt 32, the saturating count of dispatched slices.

Function
REQ-016 The block SHALL register stop into stop_reg (1-cycle delay); all stop gating SHALL use stop_reg.
REQ-017 The block SHALL hold a one-entry output buffer (buf_valid plus slice fields); data/position/address/garbage/lit_flag outputs SHALL be driven from buffer registers only.
REQ-018 The block SHALL dispatch (disp) when buf_valid & (ready!=0).
REQ-019 On disp, valid_out SHALL equal the arbiter one-hot grant for exactly that cycle; otherwise valid_out SHALL be 0.
REQ-020 The block SHALL refill (rdreq=1) when valid_in & ~stop_reg & (~buf_valid | disp).
REQ-021 On refill, the buffer SHALL capture the input slice at the clock edge and buf_valid SHALL be 1; on disp without refill, buf_valid SHALL be 0.
REQ-022 Throughput SHALL be 1 slice/cycle sustained; FIFO-to-valid_out latency SHALL be 1 cycle minimum.
REQ-023 stop_reg SHALL NOT block dispatch of an already-buffered slice (drain); it blocks only rdreq.
REQ-024 In round-robin mode, the grant SHALL be the first ready index searching cyclically from ptr upward, wrapping NUM_PARSER-1 -> 0.
REQ-025 On disp in round-robin mode, ptr SHALL be set to (granted index + 1) mod NUM_PARSER; without disp, ptr SHALL hold.
REQ-026 In fixed-priority mode, the grant SHALL be the lowest set bit of ready, and ptr SHALL be unused.
REQ-027 When ready==0 with buf_valid, the block SHALL hold the slice and ptr, with valid_out=0 and no rdreq unless the buffer is empty.
REQ-028 dispatch_cnt SHALL increment by 1 per disp and saturate at 0xFFFF_FFFF.
REQ-029 Arbitration SHALL be combinational from ready and ptr; no path from ready to rdreq SHALL exist except through disp.

Reset
REQ-030 When rst_n=0 at a clock edge: buf_valid=0, all slice registers=0, ptr=START_IDX, stop_reg=0 and dispatch_cnt=0.
REQ-031 During and after reset until the first refill, valid_out=0, rdreq=0 and idle=0.
REQ-032 Reset mid-operation SHALL discard the buffered slice without dispatching it.

Verification
REQ-033 NUM_PARSER=6, round-robin, ready=6'b111111, valid_in held 1 for 8 slices -> valid_out sequence 000001, 000010, ..., 100000, 000001, 000010; one per cycle after 1-cycle latency; dispatch_cnt=8.
REQ-034 ready=6'b100100, ptr=3, 3 slices -> grants at indices 5, 2, 5 (wrap-around).
REQ-035 Buffer full, ready=0 for 10 cycles, then ready=6'b000010 -> rdreq=0 and valid_out=0 during the stall; then valid_out=000010 with unchanged data_out, and rdreq=1 in the same cycle if valid_in=1.
REQ-036 stop asserted with buffer full -> buffered slice still dispatched; rdreq=0 from the cycle after stop; idle=1 after the drain.
REQ-037 ARB_MODE=1, ready=6'b101100 for 3 slices -> grant 000100 every time, and dispatch_cnt steps 1, 2, 3.
REQ-038 rst_n pulsed low with buffer full and ready=0 -> buffer dropped, no valid_out pulse, and after release first grant searched from START_IDX.

Source files
------------

// File: rtl/slice_dispatcher.sv
// ---------------------------------------------------------------------------
// slice_dispatcher
//
// Pops slices from a show-ahead slice FIFO into a one-entry output buffer and
// hands each buffered slice to one idle 2nd-level parser. The buffer refills
// in the same cycle it dispatches, so one slice per cycle can stream through.
//
// Parameters
//   NUM_PARSER  number of 2nd-level parsers (2..16)
//   DATA_W      slice data width
//   POS_W       position width
//   ADDR_W      address width
//   START_IDX   first parser index searched after reset
//   ARB_MODE    0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   data_in .. lit_flag_in  slice at the head of the FIFO
//   valid_in             FIFO non-empty
//   rdreq                FIFO pop, high in the cycle the slice is captured
//   stop                 halts fetching (registered before use)
//   ready                per-parser idle flags
//   data_out .. lit_flag_out  buffered slice
//   valid_out            one-hot dispatch pulse
//   idle                 buffer empty while stopped
//   dispatch_cnt         saturating count of dispatched slices
// ---------------------------------------------------------------------------
module slice_dispatcher #(
    parameter int NUM_PARSER = 6,
    parameter int DATA_W     = 144,
    parameter int POS_W      = 16,
    parameter int ADDR_W     = 17,
    parameter int START_IDX  = 0,
    parameter int ARB_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [POS_W-1:0]      position_in,
    input  logic [ADDR_W-1:0]     address_in,
    input  logic [2:0]            garbage_in,
    input  logic                  lit_flag_in,
    input  logic                  valid_in,
    output logic                  rdreq,
    input  logic                  stop,
    input  logic [NUM_PARSER-1:0] ready,
    output logic [DATA_W-1:0]     data_out,
    output logic [POS_W-1:0]      position_out,
    output logic [ADDR_W-1:0]     address_out,
    output logic [2:0]            garbage_out,
    output logic                  lit_flag_out,
    output logic [NUM_PARSER-1:0] valid_out,
    output logic                  idle,
    output logic [31:0]           dispatch_cnt
);

    localparam int PTR_W = (NUM_PARSER > 1) ? $clog2(NUM_PARSER) : 1;
    localparam logic [PTR_W:0] NP = (PTR_W+1)'(NUM_PARSER);

    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        base;
    logic [PTR_W-1:0]        off;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        next_idx;
    logic [PTR_W:0]          sum;
    logic [PTR_W:0]          sum_next;
    logic [2*NUM_PARSER-1:0] ready_x2;
    logic [NUM_PARSER-1:0]   ready_rot;
    logic [NUM_PARSER-1:0]   grant;
    logic                    any_ready;
    logic                    buf_valid;
    logic                    stop_reg;
    logic                    disp;

    // Arbiter: rotate ready so the search origin lands on bit 0, take the
    // lowest set bit, then rotate the offset back to an absolute index.
    // Fixed priority is simply a search that always starts at index 0.
    always_comb begin
        base      = (ARB_MODE == 1) ? '0 : ptr;
        ready_x2  = {ready, ready};
        ready_rot = NUM_PARSER'(ready_x2 >> base);
        any_ready = |ready;

        off = '0;
        for (int i = NUM_PARSER - 1; i >= 0; i--) begin
            if (ready_rot[i]) off = i[PTR_W-1:0];
        end

        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NP) sum = sum - NP;
        grant_idx = sum[PTR_W-1:0];

        sum_next = {1'b0, grant_idx} + (PTR_W+1)'(1);
        if (sum_next >= NP) sum_next = '0;
        next_idx = sum_next[PTR_W-1:0];

        grant = '0;
        for (int i = 0; i < NUM_PARSER; i++) begin
            grant[i] = any_ready && (grant_idx == i[PTR_W-1:0]);
        end
    end

    // Handshake: rst_n gates both dispatch and pop so nothing leaves the block
    // or the FIFO while reset is held. stop only blocks popping, so a slice
    // already buffered still drains.
    always_comb begin
        disp      = rst_n & buf_valid & any_ready;
        rdreq     = rst_n & valid_in & ~stop_reg & (~buf_valid | disp);
        valid_out = disp ? grant : '0;
        idle      = ~buf_valid & stop_reg;
    end

    // Buffer, round-robin pointer, stop register and dispatch counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid    <= 1'b0;
            data_out     <= '0;
            position_out <= '0;
            address_out  <= '0;
            garbage_out  <= '0;
            lit_flag_out <= 1'b0;
            ptr          <= PTR_W'(START_IDX);
            stop_reg     <= 1'b0;
            dispatch_cnt <= '0;
        end else begin
            stop_reg <= stop;

            if (rdreq) begin
                buf_valid    <= 1'b1;
                data_out     <= data_in;
                position_out <= position_in;
                address_out  <= address_in;
                garbage_out  <= garbage_in;
                lit_flag_out <= lit_flag_in;
            end else if (disp) begin
                buf_valid <= 1'b0;
            end

            if (disp && (ARB_MODE == 0)) ptr <= next_idx;

            if (disp && (dispatch_cnt != 32'hFFFF_FFFF)) begin
                dispatch_cnt <= dispatch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_slice_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_slice_dispatcher
//
// Directed bench for slice_dispatcher. Two instances share every input: rr
// (round-robin) and fp (fixed priority). Inputs are driven on the falling
// edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_slice_dispatcher;

    localparam int NP = 6;
    localparam int DW = 144;
    localparam int PW = 16;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic [PW-1:0] position_in;
    logic [AW-1:0] address_in;
    logic [2:0]    garbage_in;
    logic          lit_flag_in;
    logic          valid_in;
    logic          stop;
    logic [NP-1:0] ready;

    logic          rr_rdreq, fp_rdreq;
    logic [DW-1:0] rr_data_out, fp_data_out;
    logic [PW-1:0] rr_position_out, fp_position_out;
    logic [AW-1:0] rr_address_out, fp_address_out;
    logic [2:0]    rr_garbage_out, fp_garbage_out;
    logic          rr_lit_flag_out, fp_lit_flag_out;
    logic [NP-1:0] rr_valid_out, fp_valid_out;
    logic          rr_idle, fp_idle;
    logic [31:0]   rr_dispatch_cnt, fp_dispatch_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    slice_dispatcher #(.NUM_PARSER(NP), .DATA_W(DW), .POS_W(PW), .ADDR_W(AW),
                       .START_IDX(0), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .data_in(data_in), .position_in(position_in), .address_in(address_in),
        .garbage_in(garbage_in), .lit_flag_in(lit_flag_in),
        .valid_in(valid_in), .rdreq(rr_rdreq), .stop(stop), .ready(ready),
        .data_out(rr_data_out), .position_out(rr_position_out),
        .address_out(rr_address_out), .garbage_out(rr_garbage_out),
        .lit_flag_out(rr_lit_flag_out), .valid_out(rr_valid_out),
        .idle(rr_idle), .dispatch_cnt(rr_dispatch_cnt)
    );

    slice_dispatcher #(.NUM_PARSER(NP), .DATA_W(DW), .POS_W(PW), .ADDR_W(AW),
                       .START_IDX(0), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .data_in(data_in), .position_in(position_in), .address_in(address_in),
        .garbage_in(garbage_in), .lit_flag_in(lit_flag_in),
        .valid_in(valid_in), .rdreq(fp_rdreq), .stop(stop), .ready(ready),
        .data_out(fp_data_out), .position_out(fp_position_out),
        .address_out(fp_address_out), .garbage_out(fp_garbage_out),
        .lit_flag_out(fp_lit_flag_out), .valid_out(fp_valid_out),
        .idle(fp_idle), .dispatch_cnt(fp_dispatch_cnt)
    );

    // Data pattern carried by the slice tagged 'tag'.
    function automatic logic [DW-1:0] exp_data(input int tag);
        return {112'h0, 32'hD000_0000 + 32'(tag)};
    endfunction

    task automatic set_slice(input int tag);
        data_in     = exp_data(tag);
        position_in = PW'(tag);
        address_in  = AW'(tag + 7);
        garbage_in  = 3'(tag);
        lit_flag_in = tag[0];
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        stop     = 1'b0;
        ready    = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (rr_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL reset valid_out got=%b exp=%b", rr_valid_out, 6'b0); end
        checks++; if (rr_rdreq !== 1'b0) begin errors++; $display("[TB] FAIL reset rdreq got=%b exp=0", rr_rdreq); end
        checks++; if (rr_idle !== 1'b0) begin errors++; $display("[TB] FAIL reset idle got=%b exp=0", rr_idle); end
        checks++; if (rr_dispatch_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset dispatch_cnt got=%0d exp=0", rr_dispatch_cnt); end
        checks++; if (rr_data_out !== '0) begin errors++; $display("[TB] FAIL reset data_out got=%h exp=0", rr_data_out); end
        checks++; if (fp_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL reset fp valid_out got=%b exp=%b", fp_valid_out, 6'b0); end
        stop = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rr_idle !== 1'b0) begin errors++; $display("[TB] FAIL reset idle_stop got=%b exp=0", rr_idle); end
        checks++; if (rr_rdreq !== 1'b0) begin errors++; $display("[TB] FAIL reset rdreq_held got=%b exp=0", rr_rdreq); end
        stop     = 1'b0;
        valid_in = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp_vo;
        pulse_reset();
        ready = 6'b111111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            valid_in = (k < 8);
            set_slice(k + 1);
            #1;
            checks++; if (rr_rdreq !== 1'(k < 8)) begin errors++; $display("[TB] FAIL rr_rdreq k=%0d got=%b exp=%b", k, rr_rdreq, 1'(k < 8)); end
            exp_vo = (k >= 1 && k <= 8) ? NP'(1 << ((k - 1) % 6)) : '0;
            checks++; if (rr_valid_out !== exp_vo) begin errors++; $display("[TB] FAIL rr_seq k=%0d valid_out got=%b exp=%b", k, rr_valid_out, exp_vo); end
            if (k >= 1 && k <= 8) begin
                checks++; if (rr_data_out !== exp_data(k)) begin errors++; $display("[TB] FAIL rr_data k=%0d got=%h exp=%h", k, rr_data_out, exp_data(k)); end
            end
        end
        checks++; if (rr_dispatch_cnt !== 32'd8) begin errors++; $display("[TB] FAIL rr_count got=%0d exp=8", rr_dispatch_cnt); end
        checks++; if (rr_position_out !== PW'(8)) begin errors++; $display("[TB] FAIL rr_position got=%0d exp=8", rr_position_out); end
    endtask

    task automatic test_wrap();
        logic [NP-1:0] exp_tab [6] = '{6'b000001, 6'b000010, 6'b000100,
                                       6'b100000, 6'b000100, 6'b100000};
        pulse_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            valid_in = (k < 6);
            ready    = (k <= 3) ? 6'b111111 : 6'b100100;
            set_slice(k + 20);
            #1;
            if (k >= 1) begin
                checks++; if (rr_valid_out !== exp_tab[k-1]) begin errors++; $display("[TB] FAIL wrap k=%0d valid_out got=%b exp=%b", k, rr_valid_out, exp_tab[k-1]); end
            end
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        @(negedge clk);
        valid_in = 1'b1;
        ready    = '0;
        set_slice(50);
        #1;
        checks++; if (rr_rdreq !== 1'b1) begin errors++; $display("[TB] FAIL stall_fill rdreq got=%b exp=1", rr_rdreq); end
        for (int s = 1; s <= 10; s++) begin
            @(negedge clk);
            set_slice(51);
            #1;
            checks++; if (rr_rdreq !== 1'b0) begin errors++; $display("[TB] FAIL stall s=%0d rdreq got=%b exp=0", s, rr_rdreq); end
            checks++; if (rr_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL stall s=%0d valid_out got=%b exp=0", s, rr_valid_out); end
            checks++; if (rr_data_out !== exp_data(50)) begin errors++; $display("[TB] FAIL stall s=%0d data got=%h exp=%h", s, rr_data_out, exp_data(50)); end
        end
        @(negedge clk);
        ready = 6'b000010;
        #1;
        checks++; if (rr_valid_out !== 6'b000010) begin errors++; $display("[TB] FAIL stall_release valid_out got=%b exp=000010", rr_valid_out); end
        checks++; if (rr_data_out !== exp_data(50)) begin errors++; $display("[TB] FAIL stall_release data got=%h exp=%h", rr_data_out, exp_data(50)); end
        checks++; if (rr_rdreq !== 1'b1) begin errors++; $display("[TB] FAIL stall_release rdreq got=%b exp=1", rr_rdreq); end
        @(negedge clk);
        valid_in = 1'b0;
        ready    = '0;
        #1;
        checks++; if (rr_data_out !== exp_data(51)) begin errors++; $display("[TB] FAIL stall_refill data got=%h exp=%h", rr_data_out, exp_data(51)); end
        checks++; if (rr_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL stall_refill valid_out got=%b exp=0", rr_valid_out); end
        checks++; if (rr_dispatch_cnt !== 32'd1) begin errors++; $display("[TB] FAIL stall_refill count got=%0d exp=1", rr_dispatch_cnt); end
    endtask

    task automatic test_stop();
        pulse_reset();
        @(negedge clk);
        valid_in = 1'b1;
        ready    = '0;
        set_slice(60);
        @(negedge clk);
        stop = 1'b1;
        set_slice(61);
        #1;
        checks++; if (rr_idle !== 1'b0) begin errors++; $display("[TB] FAIL stop_full idle got=%b exp=0", rr_idle); end
        @(negedge clk);
        ready = 6'b111111;
        #1;
        checks++; if (rr_valid_out !== 6'b000001) begin errors++; $display("[TB] FAIL stop_drain valid_out got=%b exp=000001", rr_valid_out); end
        checks++; if (rr_data_out !== exp_data(60)) begin errors++; $display("[TB] FAIL stop_drain data got=%h exp=%h", rr_data_out, exp_data(60)); end
        checks++; if (rr_rdreq !== 1'b0) begin errors++; $display("[TB] FAIL stop_drain rdreq got=%b exp=0", rr_rdreq); end
        checks++; if (rr_idle !== 1'b0) begin errors++; $display("[TB] FAIL stop_drain idle got=%b exp=0", rr_idle); end
        @(negedge clk);
        #1;
        checks++; if (rr_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL stop_after valid_out got=%b exp=0", rr_valid_out); end
        checks++; if (rr_rdreq !== 1'b0) begin errors++; $display("[TB] FAIL stop_after rdreq got=%b exp=0", rr_rdreq); end
        checks++; if (rr_idle !== 1'b1) begin errors++; $display("[TB] FAIL stop_after idle got=%b exp=1", rr_idle); end
        checks++; if (rr_dispatch_cnt !== 32'd1) begin errors++; $display("[TB] FAIL stop_after count got=%0d exp=1", rr_dispatch_cnt); end
        @(negedge clk);
        stop     = 1'b0;
        valid_in = 1'b0;
        ready    = '0;
    endtask

    task automatic test_fixed_priority();
        logic [NP-1:0] rr_tab [3] = '{6'b000100, 6'b001000, 6'b100000};
        pulse_reset();
        ready = 6'b101100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_in = (k < 3);
            set_slice(70 + k);
            #1;
            if (k >= 1 && k <= 3) begin
                checks++; if (fp_valid_out !== 6'b000100) begin errors++; $display("[TB] FAIL fp_grant k=%0d got=%b exp=000100", k, fp_valid_out); end
                checks++; if (rr_valid_out !== rr_tab[k-1]) begin errors++; $display("[TB] FAIL rr_vs_fp k=%0d got=%b exp=%b", k, rr_valid_out, rr_tab[k-1]); end
            end
            if (k >= 2) begin
                checks++; if (fp_dispatch_cnt !== 32'(k - 1)) begin errors++; $display("[TB] FAIL fp_count k=%0d got=%0d exp=%0d", k, fp_dispatch_cnt, k - 1); end
            end
        end
        checks++; if (fp_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL fp_end valid_out got=%b exp=0", fp_valid_out); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        ready = 6'b111111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid_in = (k < 2);
            set_slice(80 + k);
        end
        @(negedge clk);
        valid_in = 1'b1;
        ready    = '0;
        set_slice(90);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++; if (rr_data_out !== exp_data(90)) begin errors++; $display("[TB] FAIL rmid_full data got=%h exp=%h", rr_data_out, exp_data(90)); end
        checks++; if (rr_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL rmid_in_reset valid_out got=%b exp=0", rr_valid_out); end
        @(negedge clk);
        rst_n = 1'b1;
        ready = 6'b111111;
        #1;
        checks++; if (rr_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL rmid_dropped valid_out got=%b exp=0", rr_valid_out); end
        checks++; if (rr_data_out !== '0) begin errors++; $display("[TB] FAIL rmid_dropped data got=%h exp=0", rr_data_out); end
        checks++; if (rr_dispatch_cnt !== 32'd0) begin errors++; $display("[TB] FAIL rmid_dropped count got=%0d exp=0", rr_dispatch_cnt); end
        @(negedge clk);
        valid_in = 1'b1;
        set_slice(91);
        #1;
        checks++; if (rr_valid_out !== 6'b0) begin errors++; $display("[TB] FAIL rmid_fill valid_out got=%b exp=0", rr_valid_out); end
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        checks++; if (rr_valid_out !== 6'b000001) begin errors++; $display("[TB] FAIL rmid_first_grant got=%b exp=000001", rr_valid_out); end
        checks++; if (rr_data_out !== exp_data(91)) begin errors++; $display("[TB] FAIL rmid_first_data got=%h exp=%h", rr_data_out, exp_data(91)); end
    endtask

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b1;
        stop     = 1'b0;
        ready    = 6'b111111;
        set_slice(0);
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_stop();
        test_fixed_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
